// File: rtl/bundle_bridge_int_sink.sv
// Sink terminator for an async level bundle: synchronize, capture events,
// accumulate into sticky pending bits and hand snapshots over valid/ready.
module bundle_bridge_int_sink #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE        = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] auto_in,
  output logic [WIDTH-1:0] sync_level,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits,
  output logic [7:0]       overflow_count
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] bits_q;
  logic [WIDTH-1:0] ev;
  logic [7:0]       ovf_q;
  logic [7:0]       ovf_d;
  logic             unload;
  logic             ovf_hit;
  state_e           state_q;

  assign sync_level     = sync_q[SYNC_STAGES-1];
  assign out_valid      = (state_q == PRESENT);
  assign out_bits       = bits_q;
  assign overflow_count = ovf_q;

  // Per-line synchronizer chain into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= auto_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Previous synchronized level, for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev_q <= '0;
    else        prev_q <= sync_level;
  end

  // Event vector, whether pending is emptied this cycle, overflow next.
  always_comb begin
    ev      = EDGE ? (sync_level & ~prev_q) : sync_level;
    unload  = (|pending_q) &&
              ((state_q == IDLE) || out_ready);
    ovf_hit = EDGE && (|(ev & pending_q)) && !unload;
    ovf_d   = ovf_q;
    if (ovf_hit && (ovf_q != 8'hFF))
      ovf_d = ovf_q + 8'd1;
  end

  // Saturating lost-event counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  // Handshake FSM: snapshot pending into out_bits, refill from events.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bits_q    <= '0;
      pending_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pending_q <= ev;
          if (|pending_q) begin
            state_q <= PRESENT;
            bits_q  <= pending_q;
          end else begin
            bits_q  <= '0;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            pending_q <= ev;
            if (|pending_q) begin
              bits_q  <= pending_q;
            end else begin
              state_q <= IDLE;
              bits_q  <= '0;
            end
          end else begin
            pending_q <= pending_q | ev;
          end
        end
      endcase
    end
  end

endmodule
